// File: rtl/slice_queue_pkg.sv
// Shared decompressor slice definitions. The distributor and the parsers use
// the same field widths and entry layout.
package slice_queue_pkg;

    localparam int unsigned DATA_W  = 144;
    localparam int unsigned POS_W   = 16;
    localparam int unsigned ADDR_W  = 17;
    localparam int unsigned GARB_W  = 3;
    localparam int unsigned LIT_W   = 1;
    localparam int unsigned ENTRY_W = DATA_W + POS_W + ADDR_W + GARB_W + LIT_W;

    // One queue entry: all five fields are stored and read as a single word
    typedef struct packed {
        logic [LIT_W-1:0]  lit_flag;
        logic [GARB_W-1:0] garbage;
        logic [ADDR_W-1:0] address;
        logic [POS_W-1:0]  position;
        logic [DATA_W-1:0] data;
    } slice_t;

endpackage

// File: rtl/slice_queue_if.sv
// Parser-to-queue-to-distributor bus. Master is the parser/distributor side;
// slave is the queue.
interface slice_queue_if
    import slice_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic              wrreq;
    logic [DATA_W-1:0] data_in;
    logic [POS_W-1:0]  position_in;
    logic [ADDR_W-1:0] address_in;
    logic [GARB_W-1:0] garbage_in;
    logic [LIT_W-1:0]  lit_flag_in;
    logic              almost_full;
    logic              full;

    logic              valid_out;
    logic              rdreq;
    logic [DATA_W-1:0] data_out;
    logic [POS_W-1:0]  position_out;
    logic [ADDR_W-1:0] address_out;
    logic [GARB_W-1:0] garbage_out;
    logic [LIT_W-1:0]  lit_flag_out;

    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, wrreq, data_in, position_in, address_in, garbage_in,
               lit_flag_in, rdreq,
        input  almost_full, full, valid_out, data_out, position_out,
               address_out, garbage_out, lit_flag_out, count, overflow,
               underflow
    );

    modport slave (
        input  flush, wrreq, data_in, position_in, address_in, garbage_in,
               lit_flag_in, rdreq,
        output almost_full, full, valid_out, data_out, position_out,
               address_out, garbage_out, lit_flag_out, count, overflow,
               underflow
    );

endinterface

// File: rtl/slice_ram.sv
// Slice storage: DEPTH x ENTRY_W simple dual-port, synchronous write and
// asynchronous read. Contents are deliberately not reset.
module slice_ram
    import slice_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  slice_t           i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output slice_t           o_rdata
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = slice_t'(r_mem[i_raddr]);

endmodule

// File: rtl/slice_queue.sv
// First-word-fall-through slice queue between the 1st-level parser and the
// distributor, with almost-full back-pressure and sticky error flags.
module slice_queue
    import slice_queue_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_MARGIN = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    slice_queue_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_LVL = CNT_W'(DEPTH - AFULL_MARGIN);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_afull;
    logic             w_valid;
    logic             w_wr_en;
    logic             w_rd_en;
    slice_t           w_wr_slice;
    slice_t           w_rd_slice;

    // Status is decoded from the count register only, so no request input
    // ever reaches valid_out/full combinationally.
    assign w_full  = (r_count == FULL_LVL);
    assign w_afull = (r_count >= AFULL_LVL);
    assign w_valid = (r_count != '0);

    // Reset and flush gate the enables so the RAM is never written then
    assign w_wr_en = rst_n & ~bus.flush & bus.wrreq & ~w_full;
    assign w_rd_en = rst_n & ~bus.flush & bus.rdreq & w_valid;

    assign w_wr_slice.data     = bus.data_in;
    assign w_wr_slice.position = bus.position_in;
    assign w_wr_slice.address  = bus.address_in;
    assign w_wr_slice.garbage  = bus.garbage_in;
    assign w_wr_slice.lit_flag = bus.lit_flag_in;

    slice_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_slice),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_slice)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (bus.wrreq && w_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.rdreq && !w_valid) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.full         = w_full;
    assign bus.almost_full  = w_afull;
    assign bus.valid_out    = w_valid;
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

    assign bus.data_out     = w_rd_slice.data;
    assign bus.position_out = w_rd_slice.position;
    assign bus.address_out  = w_rd_slice.address;
    assign bus.garbage_out  = w_rd_slice.garbage;
    assign bus.lit_flag_out = w_rd_slice.lit_flag;

endmodule

// File: tb/tb_slice_queue.sv
// Scoreboard bench for slice_queue: accepted writes are queued as expected
// entries and a negedge monitor checks every pop against the queue head.
module tb_slice_queue;
    import slice_queue_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   pops;
    slice_t exp_q[$];

    slice_queue_if #(.DEPTH(16)) bus ();

    slice_queue #(
        .DEPTH        (16),
        .AFULL_MARGIN (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic slice_t mk(input int n);
        slice_t s;
        logic [15:0] v;
        v = n[15:0];
        s.data     = {9{~v}};
        s.position = v;
        s.address  = {1'b1, v};
        s.garbage  = v[2:0];
        s.lit_flag = v[0];
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic cycle(input bit wr, input bit rd, input bit fl, input slice_t s, input bit push);
        bus.wrreq       = wr;
        bus.rdreq       = rd;
        bus.flush       = fl;
        bus.data_in     = s.data;
        bus.position_in = s.position;
        bus.address_in  = s.address;
        bus.garbage_in  = s.garbage;
        bus.lit_flag_in = s.lit_flag;
        if (push) exp_q.push_back(s);
        @(posedge clk);
        #1;
        bus.wrreq = 1'b0;
        bus.rdreq = 1'b0;
        bus.flush = 1'b0;
    endtask

    // Pops happen at the next posedge when valid_out and rdreq are both high
    always @(negedge clk) begin
        if (rst_n && !bus.flush && bus.rdreq && bus.valid_out) begin
            slice_t got;
            slice_t e;
            got = {bus.lit_flag_out, bus.garbage_out, bus.address_out,
                   bus.position_out, bus.data_out};
            checks++;
            pops++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got position %0h, expected no entry", got.position);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL pop_entry: got %0h, expected %0h", got, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        checks = 0;
        errors = 0;
        pops   = 0;
        bus.wrreq = 1'b0;
        bus.rdreq = 1'b0;
        bus.flush = 1'b0;
        bus.data_in = '0;
        bus.position_in = '0;
        bus.address_in = '0;
        bus.garbage_in = '0;
        bus.lit_flag_in = '0;

        // Reset state
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_count", bus.count, 0);
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_afull", bus.almost_full, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_unf", bus.underflow, 0);
        rst_n = 1'b1;

        // Single write falls through after one edge
        cycle(1, 0, 0, mk(16'h0010), 1);
        chk("a_valid", bus.valid_out, 1);
        chk("a_position", bus.position_out, 32'h0010);
        chk("a_count", bus.count, 1);
        cycle(0, 1, 0, '0, 0);
        chk("a_popped_count", bus.count, 0);

        // Underflow on empty
        cycle(0, 1, 0, '0, 0);
        chk("unf_flag", bus.underflow, 1);
        chk("unf_count", bus.count, 0);
        chk("unf_valid", bus.valid_out, 0);
        cycle(0, 0, 1, '0, 0);
        chk("unf_flush_clear", bus.underflow, 0);

        // Fill to full, almost_full from 12, overflow on the 17th write
        for (int i = 0; i < 16; i++) begin
            cycle(1, 0, 0, mk(100 + i), 1);
            if (i == 10) chk("afull_at_11", bus.almost_full, 0);
            if (i == 11) chk("afull_at_12", bus.almost_full, 1);
            if (i == 14) chk("full_at_15", bus.full, 0);
        end
        chk("fill_full", bus.full, 1);
        chk("fill_count", bus.count, 16);
        cycle(1, 0, 0, mk(999), 0);
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_count", bus.count, 16);
        chk("ovf_head", bus.position_out, 100);
        for (int i = 0; i < 16; i++) cycle(0, 1, 0, '0, 0);
        chk("drain_count", bus.count, 0);
        chk("drain_valid", bus.valid_out, 0);
        chk("ovf_sticky", bus.overflow, 1);
        cycle(0, 0, 1, '0, 0);
        chk("ovf_flush_clear", bus.overflow, 0);

        // Simultaneous write and pop at count 5
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, mk(200 + i), 1);
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, mk(205 + i), 1);
        chk("wrrd_count", bus.count, 5);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, '0, 0);
        chk("wrrd_drained", bus.count, 0);

        // 20 writes with interleaved pops across the pointer wrap
        p0 = pops;
        for (int i = 0; i < 20; i++) cycle(1, (i % 4) != 0, 0, mk(300 + i), 1);
        chk("wrap_count", bus.count, 5);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, '0, 0);
        chk("wrap_pops", pops - p0, 20);
        chk("wrap_empty", bus.valid_out, 0);

        // Flush with a simultaneous write at count 7
        cycle(0, 1, 0, '0, 0);
        for (int i = 0; i < 7; i++) cycle(1, 0, 0, mk(400 + i), 1);
        chk("pre_flush_count", bus.count, 7);
        chk("pre_flush_unf", bus.underflow, 1);
        cycle(1, 0, 1, mk(407), 0);
        exp_q.delete();
        chk("flush_count", bus.count, 0);
        chk("flush_valid", bus.valid_out, 0);
        chk("flush_unf", bus.underflow, 0);
        chk("flush_ovf", bus.overflow, 0);
        cycle(0, 0, 0, '0, 0);
        chk("flush_still_empty", bus.valid_out, 0);

        // Reset mid-stream overrides a concurrent write
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, mk(500 + i), 1);
        rst_n = 1'b0;
        cycle(1, 0, 0, mk(503), 0);
        exp_q.delete();
        chk("rst_mid_count", bus.count, 0);
        chk("rst_mid_valid", bus.valid_out, 0);
        rst_n = 1'b1;
        cycle(1, 0, 0, mk(600), 1);
        chk("post_rst_head", bus.position_out, 600);
        cycle(0, 1, 0, '0, 0);
        chk("model_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slice_queue.md
SLICE_QUEUE -- requirements
Module: slice_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of slice entries (power of two, >=4).
REQ-002 SHALL have parameter AFULL_MARGIN, default 4, meaning free-entry count at which almost_full asserts.
REQ-003 SHALL have ports: clk input 1, clock; rst_n input 1, reset, synchronous, active-low.
REQ-004 SHALL have ports: flush input 1, synchronous clear of queue contents.
REQ-005 SHALL have ports: wrreq input 1, write strobe from 1st-level parser.
REQ-006 SHALL have ports: data_in input 144, slice payload.
REQ-007 SHALL have ports: position_in input 16, address_in input 17, garbage_in input 3, lit_flag_in input 1, slice fields.
REQ-008 SHALL have ports: almost_full output 1, back-pressure to 1st-level parser.
REQ-009 SHALL have ports: full output 1, queue holds DEPTH entries.
REQ-010 SHALL have ports: valid_out output 1, head entry present (drives distributor valid_in).
REQ-011 SHALL have ports: rdreq input 1, pop strobe from distributor.
REQ-012 SHALL have ports: data_out output 144, position_out output 16, address_out output 17, garbage_out output 3, lit_flag_out output 1, head slice fields.
REQ-013 SHALL have ports: count output log2(DEPTH)+1, entries held.
REQ-014 SHALL have ports: overflow output 1 and underflow output 1, sticky error flags.

Function
REQ-015 SHALL store all five fields of a slice as one 181-bit entry, written and read atomically.
REQ-016 SHALL be first-word-fall-through: head entry fields drive outputs whenever valid_out=1, with no rdreq needed to present it.
REQ-017 SHALL drive valid_out = (count != 0), registered-derived, with no combinational path from rdreq or wrreq.
REQ-018 SHALL accept a write on a clk edge iff wrreq=1 and full=0; full is evaluated pre-edge; a same-cycle pop does not admit a write when full.
REQ-019 SHALL pop the head on a clk edge iff rdreq=1 and valid_out=1.
REQ-020 SHALL give latency of 1 cycle: an entry written at edge N into an empty queue appears with valid_out=1 after edge N.
REQ-021 SHALL handle simultaneous accepted write and pop by leaving count unchanged and advancing both pointers.
REQ-022 SHALL update count +1 on write only, -1 on pop only, and leave it unchanged on both or neither.
REQ-023 SHALL hold full = (count == DEPTH).
REQ-024 SHALL hold almost_full = (count >= DEPTH - AFULL_MARGIN).
REQ-025 SHALL wrap pointers modulo DEPTH, using an extra MSB or the count to distinguish full from empty.
REQ-026 SHALL, on wrreq=1 while full=1, drop the data, keep contents unchanged and set overflow=1 until reset or flush.
REQ-027 SHALL, on rdreq=1 while valid_out=0, keep state unchanged and set underflow=1 until reset or flush.
REQ-028 SHALL, on flush=1, zero pointers, count, overflow and underflow at the edge; flush overrides same-cycle wrreq and rdreq, and valid_out=0 the next cycle.
REQ-029 SHALL preserve order strictly FIFO.

Reset
REQ-030 SHALL, on rst_n=0 at a clk edge, set pointers=0, count=0, valid_out=0, full=0, almost_full=0, overflow=0 and underflow=0.
REQ-031 SHALL leave storage array contents unreset.
REQ-032 SHALL drive data_out, position_out, address_out, garbage_out and lit_flag_out don't-care while valid_out=0.
REQ-033 SHALL let reset override flush, wrreq and rdreq; reset mid-stream discards all entries.

Structure
REQ-034 SHALL place the field-width constants (144, 16, 17, 3, 1) and the 181-bit entry width in the shared decompressor package, also used by distributor and parsers.
REQ-035 SHALL put storage in one sub-module, slice_ram: DEPTH x 181 simple dual-port, synchronous write, asynchronous read at rd_ptr.
REQ-036 SHALL keep pointer, count and flag logic in slice_queue.

Verification
REQ-037 SHALL cover: reset, then write slice A (position_in=16'h0010) at edge 1 -> valid_out=1 and position_out=16'h0010 after edge 1; count=1.
REQ-038 SHALL cover: DEPTH=16, 16 writes with no pops -> full=1 and count=16; almost_full=1 from count 12; 17th write -> overflow=1 and head unchanged.
REQ-039 SHALL cover: with count=5, wrreq=1 and rdreq=1 for 10 cycles -> count stays 5 and output order matches input order.
REQ-040 SHALL cover: empty queue with rdreq=1 -> underflow=1, count=0, valid_out=0.
REQ-041 SHALL cover: write 20 and pop 20 interleaved across wrap -> all 181-bit entries match in order.
REQ-042 SHALL cover: count=7 with flush=1 and wrreq=1 simultaneous -> count=0, valid_out=0, flags clear next cycle.
